// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared FSM state encoding and default widths for the instruction fetch unit
//
// Purpose: holds the fetch FSM state encoding and the default instruction and address widths.
// Ports: none (package).
package ifetch_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit driving a synchronous-read instruction memory
//
// Purpose: issues instruction memory addresses and presents the returned word to decode,
//          with stall hold, zero-bubble redirect, halt/resume and a consumed-instruction count.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   stall           decode not ready, hold the presented instruction
//   jmp, jmp_addr   single-cycle redirect request and target
//   halt            stop fetching after the current instruction
//   ib_addr         combinational address to the instruction memory
//   ib_dout         memory data for the address issued one cycle earlier
//   ins, ins_pc     instruction to decode and its address
//   ins_vld         ins/ins_pc are valid
//   fetch_cnt       wrapping count of consumed instructions
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              DW     = DW_DEF,
  parameter int              AW     = AW_DEF,
  parameter logic [AW-1:0]   RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_addr,
  input  logic          halt,
  output logic [AW-1:0] ib_addr,
  input  logic [DW-1:0] ib_dout,
  output logic [DW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  output logic          ins_vld,
  output logic [15:0]   fetch_cnt
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] f_pc;
  logic          consume;

  // f_pc is the address issued last cycle, so it names the word the memory returns now.
  assign ins    = ib_dout;
  assign ins_pc = f_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      f_pc      <= RST_PC;
      fetch_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      f_pc  <= ib_addr;
      if (consume) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ib_addr   = f_pc;
    ins_vld   = 1'b0;
    consume   = 1'b0;
    unique case (state)
      BOOT: begin
        ib_addr   = RST_PC;
        state_nxt = RUN;
      end
      RUN: begin
        ins_vld = 1'b1;
        // A jump with stall=0 still consumes the current instruction; with stall=1 it is dropped.
        consume = ~stall;
        if (jmp) begin
          ib_addr = jmp_addr;
        end else if (stall) begin
          // Re-issue the same address so the memory keeps returning the held word.
          ib_addr = f_pc;
        end else begin
          ib_addr = f_pc + AW'(1);
          if (halt) begin
            state_nxt = HALT;
          end
        end
      end
      HALT: begin
        if (jmp) begin
          ib_addr   = jmp_addr;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for the instruction fetch unit
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic        halt;
  logic [15:0] ib_addr;
  logic [15:0] ib_dout;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        ins_vld;
  logic [15:0] fetch_cnt;

  int errors;
  int checks;

  logic [15:0] mem [0:65535];

  ifetch #(.DW(16), .AW(16), .RST_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .halt      (halt),
    .ib_addr   (ib_addr),
    .ib_dout   (ib_dout),
    .ins       (ins),
    .ins_pc    (ins_pc),
    .ins_vld   (ins_vld),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory, write port tied off.
  always @(posedge clk) ib_dout <= mem[ib_addr];

  function automatic logic [15:0] mem_exp(input logic [15:0] a);
    case (a)
      16'h0000: mem_exp = 16'hAAAA;
      16'h0001: mem_exp = 16'hBBBB;
      16'h0002: mem_exp = 16'hCCCC;
      16'h0003: mem_exp = 16'hDDDD;
      default:  mem_exp = a ^ 16'h5A5A;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag, input logic [15:0] pc, input logic [15:0] cnt);
    chk({tag, "_vld"}, 16'(ins_vld), 16'h0001);
    chk({tag, "_pc"}, ins_pc, pc);
    chk({tag, "_ins"}, ins, mem_exp(pc));
    chk({tag, "_cnt"}, fetch_cnt, cnt);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    jmp      = 1'b0;
    jmp_addr = 16'h0000;
    halt     = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = mem_exp(16'(i));

    // Held in reset.
    tick();
    tick();
    chk("rst_vld", 16'(ins_vld), 16'h0000);
    chk("rst_pc", ins_pc, 16'h0000);
    chk("rst_addr", ib_addr, 16'h0000);
    chk("rst_cnt", fetch_cnt, 16'h0000);

    // Release: one BOOT cycle, then A,B,C,D back to back.
    rst = 1'b0;
    #1;
    chk("boot_vld", 16'(ins_vld), 16'h0000);
    chk("boot_addr", ib_addr, 16'h0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_run("seq", 16'(i), 16'(i));
      tick();
    end
    chk("seq_cnt4", fetch_cnt, 16'h0004);
    chk("seq_pc4", ins_pc, 16'h0004);

    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_vld", 16'(ins_vld), 16'h0000);
    chk("arst_addr", ib_addr, 16'h0000);
    chk("arst_cnt", fetch_cnt, 16'h0000);
    chk("arst_pc", ins_pc, 16'h0000);
    #1;
    rst = 1'b0;
    #1;
    chk("reboot_vld", 16'(ins_vld), 16'h0000);
    tick();
    chk_run("re0", 16'h0000, 16'h0000);
    tick();
    chk_run("re1", 16'h0001, 16'h0001);

    // Stall three cycles on B.
    stall = 1'b1;
    #1;
    chk("stall_addr", ib_addr, 16'h0001);
    chk_run("stall0", 16'h0001, 16'h0001);
    tick();
    chk_run("stall1", 16'h0001, 16'h0001);
    tick();
    chk_run("stall2", 16'h0001, 16'h0001);
    stall = 1'b0;
    tick();
    chk_run("unstall", 16'h0002, 16'h0002);

    // Jump at ins_pc=2: C is consumed, target appears next cycle.
    jmp      = 1'b1;
    jmp_addr = 16'h0100;
    halt     = 1'b1;
    #1;
    chk("jmp_addr", ib_addr, 16'h0100);
    tick();
    jmp  = 1'b0;
    halt = 1'b0;
    chk_run("jmp", 16'h0100, 16'h0003);

    // Jump together with stall: jump wins, held instruction not counted.
    jmp      = 1'b1;
    jmp_addr = 16'h0200;
    stall    = 1'b1;
    tick();
    jmp   = 1'b0;
    stall = 1'b0;
    chk_run("jmpstall", 16'h0200, 16'h0003);
    tick();
    chk_run("after_js", 16'h0201, 16'h0004);

    // Address wrap from 0xFFFF to 0x0000.
    jmp      = 1'b1;
    jmp_addr = 16'hFFFF;
    tick();
    jmp = 1'b0;
    chk_run("top", 16'hFFFF, 16'h0005);
    tick();
    chk_run("wrap", 16'h0000, 16'h0006);

    // Halt at ins_pc=5, idle with stall ignored, resume by jump.
    for (int i = 0; i < 5; i++) tick();
    chk_run("pre_halt", 16'h0005, 16'h000B);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stall = (i >= 2);
      chk("halt_vld", 16'(ins_vld), 16'h0000);
      chk("halt_cnt", fetch_cnt, 16'h000C);
      tick();
    end
    stall    = 1'b0;
    jmp      = 1'b1;
    jmp_addr = 16'h0020;
    #1;
    chk("resume_addr", ib_addr, 16'h0020);
    tick();
    jmp = 1'b0;
    chk_run("resume", 16'h0020, 16'h000C);
    tick();
    chk_run("resume1", 16'h0021, 16'h000D);

    // Halt with stall is ignored.
    halt  = 1'b1;
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk_run("halt_stall", 16'h0021, 16'h000D);

    // Halt with jump: jump wins, stays in RUN.
    jmp      = 1'b1;
    jmp_addr = 16'h0030;
    tick();
    jmp  = 1'b0;
    halt = 1'b0;
    chk_run("halt_jmp", 16'h0030, 16'h000E);
    tick();
    chk_run("halt_jmp1", 16'h0031, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter DW, default 16: instruction width, equal to the instruction memory data width.
REQ-002 Parameter AW, default 16: PC and instruction memory address width.
REQ-003 Parameter RST_PC, default 0: first fetch address after reset.
REQ-004 clk  in  1  single clock for the block; all registers on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  downstream not ready; the presented instruction is held.
REQ-007 jmp  in  1  redirect request, single-cycle pulse, qualified every cycle.
REQ-008 jmp_addr  in  AW  redirect target.
REQ-009 halt  in  1  stop fetching after the current instruction.
REQ-010 ib_addr  out  AW  address to the instruction memory, combinational.
REQ-011 ib_dout  in  DW  memory data for the address presented one cycle earlier.
REQ-012 ins  out  DW  instruction to decode (ib_dout passed through).
REQ-013 ins_pc  out  AW  address of ins.
REQ-014 ins_vld  out  1  ins/ins_pc are valid.
REQ-015 fetch_cnt  out  16  count of consumed instructions.

Function
REQ-016 Internal register f_pc SHALL hold the address issued last cycle, so that ins_pc = f_pc and ins = ib_dout.
REQ-017 An instruction is consumed in a cycle when ins_vld=1 and stall=0.
REQ-018 The FSM states SHALL be BOOT, RUN and HALT.
REQ-019 BOOT: ib_addr=RST_PC, ins_vld=0; the next state SHALL be RUN unconditionally.
REQ-020 In RUN, ib_addr SHALL be selected by priority: jmp -> jmp_addr; else stall -> f_pc (re-issue, so the data is held); else f_pc+1.
REQ-021 In RUN, ins_vld=1.
REQ-022 f_pc+1 SHALL wrap modulo 2^AW (2^AW-1 -> 0).
REQ-023 Every cycle f_pc SHALL load ib_addr.
REQ-024 Latency: jmp at cycle N -> ins=mem[jmp_addr], ins_pc=jmp_addr, ins_vld=1 at N+1, with zero bubbles.
REQ-025 jmp and stall in the same cycle: the jump wins; the held instruction is dropped and is not counted.
REQ-026 In RUN, halt=1 with stall=0 and jmp=0: the instruction is consumed and the next state is HALT.
REQ-027 In RUN, halt with stall: halt is ignored; decode re-asserts it.
REQ-028 In RUN, halt with jmp: jmp has priority and the state stays RUN.
REQ-029 HALT: ins_vld=0, ib_addr=f_pc, no counting.
REQ-030 HALT with jmp=1: ib_addr=jmp_addr, next state RUN.
REQ-031 HALT: stall is ignored.
REQ-032 fetch_cnt SHALL increment on each consumed instruction and wrap at 16 bits.

Reset
REQ-033 While rst=1: state=BOOT, f_pc=RST_PC, fetch_cnt=0, ins_vld=0, ins_pc=RST_PC, ib_addr=RST_PC.
REQ-034 ins is not reset (it is a memory passthrough).
REQ-035 rst asserted mid-operation SHALL abort immediately and asynchronously.
REQ-036 After rst deasserts, the first valid instruction SHALL appear 2 cycles later (BOOT, then RUN).
REQ-037 No memory content is assumed valid before BOOT.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding constants (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the default DW/AW.
REQ-039 ifetch SHALL be a single module with no sub-modules.
REQ-040 ifetch SHALL connect ib_addr/ib_dout directly to the addr/dout of the synchronous-read instruction memory (we tied low).

Verification
REQ-041 Reset release with mem[0..3]=A,B,C,D and stall=0 -> ins_vld=0 for one cycle, then (ins,ins_pc)=(A,0),(B,1),(C,2),(D,3) on consecutive cycles; fetch_cnt=4.
REQ-042 stall high 3 cycles while ins_pc=1 -> ins stays B and ins_pc stays 1 for 3 cycles; fetch_cnt unchanged; C follows on release.
REQ-043 jmp with jmp_addr=0x0100 at ins_pc=2 -> next cycle ins_pc=0x0100, ins=mem[0x0100], ins_vld=1; jmp plus stall together -> same result, the stalled instruction is not counted.
REQ-044 f_pc=0xFFFF with no stall -> next ins_pc=0x0000.
REQ-045 halt at ins_pc=5 -> ins_vld=0 from the next cycle; idle 4 cycles; jmp to 0x0020 -> ins_pc=0x0020 valid the next cycle.
REQ-046 rst pulsed mid-run (asynchronous, between edges) -> ins_vld=0 and ib_addr=RST_PC immediately; fetch_cnt=0; REQ-041 sequence restarts.
